// File: rtl/overture_io_host.sv
// Host-side endpoint of the OVERTURE level I/O interface: an input FIFO feeding the CPU and an output FIFO draining it.
// Optional `OVERTURE_IO_LEVEL_EN adds in_level/out_level occupancy outputs and a saturating out_words counter.
module overture_io_host #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arch_input_enable,
  output logic [DATA_WIDTH-1:0] arch_input_value,
  input  logic                  arch_output_enable,
  input  logic [DATA_WIDTH-1:0] arch_output_value,
  input  logic                  in_wr_valid,
  input  logic [DATA_WIDTH-1:0] in_wr_data,
  output logic                  in_wr_ready,
  output logic                  out_rd_valid,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  input  logic                  out_rd_ready,
  output logic                  stall,
  input  logic                  err_clear,
  output logic                  in_underflow,
  output logic                  out_overflow
`ifdef OVERTURE_IO_LEVEL_EN
  ,
  output logic [$clog2(IN_DEPTH):0]  in_level,
  output logic [$clog2(OUT_DEPTH):0] out_level,
  output logic [15:0]                out_words
`endif
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] in_mem  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [IAW-1:0] in_wr_ptr, in_rd_ptr;
  logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
  logic [IAW:0]   in_count;
  logic [OAW:0]   out_count;

  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;
  logic in_under_evt, out_over_evt;

  always_comb begin
    in_empty     = (in_count == '0);
    in_full      = (in_count == IN_FULL);
    out_empty    = (out_count == '0);
    out_full     = (out_count == OUT_FULL);
    // Ready depends only on the registered count, so a same-cycle CPU pop never frees a slot for the host.
    in_wr_ready  = !in_full;
    out_rd_valid = !out_empty;
    in_push      = in_wr_valid & !in_full;
    in_pop       = arch_input_enable & !in_empty;
    out_push     = arch_output_enable & !out_full;
    out_pop      = out_rd_ready & !out_empty;
    in_under_evt = arch_input_enable & in_empty;
    out_over_evt = arch_output_enable & out_full;
    stall        = in_under_evt | out_over_evt;
    arch_input_value = in_empty  ? '0 : in_mem[in_rd_ptr];
    out_rd_data      = out_empty ? '0 : out_mem[out_rd_ptr];
  end

  // NOTE: storage arrays are not reset; the counts gate every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr]   <= in_wr_data;
    if (out_push) out_mem[out_wr_ptr] <= arch_output_value;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_ptr    <= '0;
      in_rd_ptr    <= '0;
      in_count     <= '0;
      out_wr_ptr   <= '0;
      out_rd_ptr   <= '0;
      out_count    <= '0;
      in_underflow <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (in_push)  in_wr_ptr  <= in_wr_ptr + IAW'(1);
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + IAW'(1);
      if (out_push) out_wr_ptr <= out_wr_ptr + OAW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OAW'(1);

      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + (IAW+1)'(1);
        2'b01:   in_count <= in_count - (IAW+1)'(1);
        default: in_count <= in_count;
      endcase
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + (OAW+1)'(1);
        2'b01:   out_count <= out_count - (OAW+1)'(1);
        default: out_count <= out_count;
      endcase

      // A new error event outranks a simultaneous clear.
      if (in_under_evt)   in_underflow <= 1'b1;
      else if (err_clear) in_underflow <= 1'b0;
      if (out_over_evt)   out_overflow <= 1'b1;
      else if (err_clear) out_overflow <= 1'b0;
    end
  end

`ifdef OVERTURE_IO_LEVEL_EN
  logic [15:0] out_words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out_words_q <= '0;
    else if (out_push && out_words_q != 16'hFFFF)
      out_words_q <= out_words_q + 16'd1;
  end

  assign in_level  = in_count;
  assign out_level = out_count;
  assign out_words = out_words_q;
`endif

endmodule

// File: tb/tb_overture_io_host.sv
// Directed self-checking bench for overture_io_host using scoreboard queues for both FIFOs.
module tb_overture_io_host;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          arch_input_enable;
  logic [DW-1:0] arch_input_value;
  logic          arch_output_enable;
  logic [DW-1:0] arch_output_value;
  logic          in_wr_valid;
  logic [DW-1:0] in_wr_data;
  logic          in_wr_ready;
  logic          out_rd_valid;
  logic [DW-1:0] out_rd_data;
  logic          out_rd_ready;
  logic          stall;
  logic          err_clear;
  logic          in_underflow;
  logic          out_overflow;
`ifdef OVERTURE_IO_LEVEL_EN
  logic [4:0]    in_level;
  logic [4:0]    out_level;
  logic [15:0]   out_words;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] in_q  [$];
  logic [DW-1:0] out_q [$];

  overture_io_host #(.DATA_WIDTH(DW), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .arch_input_enable  (arch_input_enable),
    .arch_input_value   (arch_input_value),
    .arch_output_enable (arch_output_enable),
    .arch_output_value  (arch_output_value),
    .in_wr_valid        (in_wr_valid),
    .in_wr_data         (in_wr_data),
    .in_wr_ready        (in_wr_ready),
    .out_rd_valid       (out_rd_valid),
    .out_rd_data        (out_rd_data),
    .out_rd_ready       (out_rd_ready),
    .stall              (stall),
    .err_clear          (err_clear),
    .in_underflow       (in_underflow),
    .out_overflow       (out_overflow)
`ifdef OVERTURE_IO_LEVEL_EN
    ,
    .in_level           (in_level),
    .out_level          (out_level),
    .out_words          (out_words)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change there, checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arch_input_enable  = 1'b0;
    arch_output_enable = 1'b0;
    arch_output_value  = '0;
    in_wr_valid        = 1'b0;
    in_wr_data         = '0;
    out_rd_ready       = 1'b0;
    err_clear          = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_v;

    // Reset held with stimulus active.
    rst = 1'b0;
    idle_inputs();
    in_wr_valid        = 1'b1;
    in_wr_data         = 8'h77;
    arch_output_enable = 1'b1;
    arch_output_value  = 8'h66;
    out_rd_ready       = 1'b1;
    repeat (3) tick();
    #2;
    check("rst_in_value",  arch_input_value, 0);
    check("rst_wr_ready",  in_wr_ready, 1);
    check("rst_rd_valid",  out_rd_valid, 0);
    check("rst_rd_data",   out_rd_data, 0);
    check("rst_underflow", in_underflow, 0);
    check("rst_overflow",  out_overflow, 0);
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    #2;
    check("rel_wr_ready", in_wr_ready, 1);
    check("rel_rd_valid", out_rd_valid, 0);
    check("rel_stall",    stall, 0);

    // Input ordering.
    for (int i = 1; i <= 3; i++) begin
      in_wr_valid = 1'b1;
      in_wr_data  = DW'(i * 8'h11);
      tick();
      in_q.push_back(DW'(i * 8'h11));
    end
    in_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arch_input_enable = 1'b1;
      #2;
      exp_v = in_q.pop_front();
      check("in_order_value", arch_input_value, exp_v);
      check("in_order_stall", stall, 0);
      tick();
    end
    arch_input_enable = 1'b0;
    #2;
    check("in_drained_value", arch_input_value, 0);
    check("in_drained_ready", in_wr_ready, 1);

    // Underflow, clear, and set-wins-over-clear.
    tick();
    arch_input_enable = 1'b1;
    #2;
    check("uf_stall", stall, 1);
    check("uf_value", arch_input_value, 0);
    check("uf_flag_before", in_underflow, 0);
    tick();
    arch_input_enable = 1'b0;
    #2;
    check("uf_flag_set", in_underflow, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #2;
    check("uf_flag_cleared", in_underflow, 0);
    arch_input_enable = 1'b1;
    err_clear = 1'b1;
    tick();
    arch_input_enable = 1'b0;
    #2;
    check("uf_set_wins", in_underflow, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Output FIFO fill, overflow, rejected push during pop, drain.
    for (int i = 0; i < 16; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value  = DW'(i);
      #2;
      if (i == 15) check("of_last_stall", stall, 0);
      tick();
      out_q.push_back(DW'(i));
    end
    arch_output_value = 8'hAA;
    #2;
    check("of_stall", stall, 1);
    tick();
    arch_output_enable = 1'b0;
    #2;
    check("of_flag", out_overflow, 1);
    check("of_valid", out_rd_valid, 1);
    arch_output_enable = 1'b1;
    arch_output_value  = 8'hBB;
    out_rd_ready       = 1'b1;
    #2;
    check("of_pop_stall", stall, 1);
    exp_v = out_q.pop_front();
    check("of_pop_data", out_rd_data, exp_v);
    tick();
    arch_output_enable = 1'b0;
    for (int i = 0; i < 40 && out_q.size() > 0; i++) begin
      #2;
      check("drain_valid", out_rd_valid, 1);
      exp_v = out_q.pop_front();
      check("drain_data", out_rd_data, exp_v);
      tick();
    end
    check("drain_queue_empty", out_q.size(), 0);
    #2;
    check("drain_end_valid", out_rd_valid, 0);
    check("drain_end_data", out_rd_data, 0);
    out_rd_ready = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #2;
    check("of_flag_cleared", out_overflow, 0);

    // Simultaneous host push and CPU pop with one word held.
    in_wr_valid = 1'b1;
    in_wr_data  = 8'hA1;
    tick();
    in_q.push_back(8'hA1);
    in_wr_data        = 8'h5A;
    arch_input_enable = 1'b1;
    #2;
    exp_v = in_q.pop_front();
    check("conc_old_head", arch_input_value, exp_v);
    tick();
    in_q.push_back(8'h5A);
    in_wr_valid = 1'b0;
    arch_input_enable = 1'b0;
    #2;
    exp_v = in_q.pop_front();
    check("conc_new_head", arch_input_value, exp_v);
    arch_input_enable = 1'b1;
    tick();
    arch_input_enable = 1'b0;
    #2;
    check("conc_count_one", arch_input_value, 0);

    // Input full: ready low and no push bypass on a same-cycle pop.
    for (int i = 0; i < 16; i++) begin
      in_wr_valid = 1'b1;
      in_wr_data  = DW'(8'h80 + i);
      tick();
      in_q.push_back(DW'(8'h80 + i));
    end
    in_wr_data = 8'hEE;
    arch_input_enable = 1'b1;
    #2;
    check("full_ready", in_wr_ready, 0);
    exp_v = in_q.pop_front();
    check("full_head", arch_input_value, exp_v);
    tick();
    in_wr_valid = 1'b0;
    arch_input_enable = 1'b1;
    for (int i = 0; i < 40 && in_q.size() > 0; i++) begin
      #2;
      exp_v = in_q.pop_front();
      check("full_drain", arch_input_value, exp_v);
      tick();
    end
    arch_input_enable = 1'b0;
    #2;
    check("full_no_bypass", arch_input_value, 0);

    // Async reset mid-stream with both FIFOs half full.
    for (int i = 0; i < 8; i++) begin
      in_wr_valid        = 1'b1;
      in_wr_data         = DW'(8'h40 + i);
      arch_output_enable = 1'b1;
      arch_output_value  = DW'(8'hC0 + i);
      tick();
    end
    idle_inputs();
    #1;
    check("pre_rst_valid", out_rd_valid, 1);
    check("pre_rst_value", arch_input_value, 8'h40);
    rst = 1'b0;
    #1;
    check("async_in_value", arch_input_value, 0);
    check("async_wr_ready", in_wr_ready, 1);
    check("async_rd_valid", out_rd_valid, 0);
    check("async_rd_data",  out_rd_data, 0);
    tick();
    rst = 1'b1;
    tick();
    #2;
    check("post_rst_valid", out_rd_valid, 0);
    check("post_rst_value", arch_input_value, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/overture_io_host.md
Name: overture_io_host

Overview:
- Host-side endpoint of the OVERTURE level I/O interface.
- Drives the CPU's input value port from an input FIFO filled by the host.
- Captures every CPU output strobe into an output FIFO that the host drains.
- Flags underflow/overflow so the bench or SoC can stall or fail the program.

Parameters:
- DATA_WIDTH, 8, width of the arch value buses and FIFO entries.
- IN_DEPTH, 16, input FIFO entries; power of two, minimum 2.
- OUT_DEPTH, 16, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- arch_input_enable  in  1  CPU is executing an input-read instruction this cycle.
- arch_input_value  out  DATA_WIDTH  value presented to the CPU (input FIFO head).
- arch_output_enable  in  1  CPU is executing an output instruction this cycle.
- arch_output_value  in  DATA_WIDTH  value written by the CPU.
- in_wr_valid  in  1  host offers a word to the input FIFO.
- in_wr_data  in  DATA_WIDTH  host word.
- in_wr_ready  out  1  input FIFO not full.
- out_rd_valid  out  1  output FIFO not empty.
- out_rd_data  out  DATA_WIDTH  output FIFO head, first-word-fall-through.
- out_rd_ready  in  1  host accepts the head word.
- stall  out  1  combinational; high when (arch_input_enable and input FIFO empty) or (arch_output_enable and output FIFO full).
- err_clear  in  1  synchronous clear of the sticky flags.
- in_underflow  out  1  sticky flag: a CPU read occurred with the input FIFO empty.
- out_overflow  out  1  sticky flag: a CPU write occurred with the output FIFO full.

Behaviour:
Reset (rst=0, asynchronous):
- Both FIFOs empty; read and write pointers and counts = 0.
- in_underflow = 0, out_overflow = 0.
- arch_input_value = 0, in_wr_ready = 1, out_rd_valid = 0, out_rd_data = 0.

Input FIFO:
- Host push on (in_wr_valid & in_wr_ready).
- arch_input_value = head word when non-empty, 0 when empty (combinational, zero latency).
- CPU pop at the clock edge on (arch_input_enable & !empty).
- Push and pop in the same cycle: both take effect, count unchanged.
- in_wr_ready = !full, evaluated before any same-cycle pop (no full-bypass).
- A word pushed at edge N is visible on arch_input_value after edge N (one-cycle latency).

Output FIFO:
- CPU push at the edge on (arch_output_enable & !full), storing arch_output_value.
- Host pop on (out_rd_valid & out_rd_ready).
- Simultaneous push and pop: both take effect.
- Push is rejected while full, even if the host pops in the same cycle.
- A word pushed at edge N raises out_rd_valid after edge N.

Error handling:
- arch_input_enable with the input FIFO empty: no pop; the CPU sees 0; in_underflow set at the edge.
- arch_output_enable with the output FIFO full: word dropped; out_overflow set at the edge.
- err_clear = 1: both flags cleared; a set condition in the same cycle wins (flag stays 1).

General:
- Pointers wrap modulo depth.
- Counts are stored as log2(depth)+1 bits.
- full when count == depth; empty when count == 0.
- Both enables high in one cycle is legal; the two FIFOs are independent.
- Reset asserted mid-transfer discards all contents immediately.

Optional Feature:
- Macro: OVERTURE_IO_LEVEL_EN.
- Defined:
  - Adds outputs in_level [log2(IN_DEPTH):0] and out_level [log2(OUT_DEPTH):0], equal to the current FIFO counts (registered, 0 at reset).
  - Adds out_words [15:0], a saturating count of output words accepted since reset (holds at 0xFFFF).
- Undefined: these ports and the saturating counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with stimulus active -> all outputs at reset values; release -> in_wr_ready=1, out_rd_valid=0, stall=0.
- Input ordering: push 0x11, 0x22, 0x33; then arch_input_enable=1 for 3 cycles -> arch_input_value shows 0x11, 0x22, 0x33 on successive cycles; then 0x00 and in_wr_ready=1.
- Underflow: input FIFO empty and arch_input_enable=1 -> stall=1 that cycle, arch_input_value=0, in_underflow=1 next cycle; err_clear=1 -> flag returns to 0.
- Output full: out_rd_ready=0, write 16 words 0x00..0x0F, then 0xAA -> 0xAA dropped, stall=1, out_overflow=1; drain -> exactly 0x00..0x0F in order.
- Concurrency: input FIFO holding 1 word, host pushes 0x5A while the CPU reads in the same cycle -> CPU gets the old head, 0x5A becomes the head, count stays 1.
- Async reset mid-stream: assert rst=0 between edges while both FIFOs are half full -> both FIFOs empty immediately, no clock edge required.
